serial_msg_tx: RTL and testbench



---
 rtl/serial_msg_tx_pkg.sv | 29 ++
 rtl/serial_msg_tx_pw_symbol_gen.sv | 57 +++++
 rtl/serial_msg_tx.sv | 218 +++++++++++++++++++++
 tb/tb_serial_msg_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_msg_tx_pkg.sv
// Shared definitions for the serial key/message link (transmitter and receiver).
package serial_msg_tx_pkg;

  localparam int A             = 5;               // log2 of data width
  localparam int D_SIZE        = 2 ** A;          // data/key width
  localparam int N_W           = 4;               // width of the n field
  localparam int CFG_BITS      = N_W + 2 * D_SIZE; // n, d, N on the config frame
  localparam int SYM_LONG_DEF  = 12;
  localparam int SYM_SHORT_DEF = 4;
  localparam int GAP_CYC_DEF   = 2;
  localparam int BIT_CNT_W     = 7;               // counts 0..CFG_BITS-1
  localparam int SYM_CNT_W     = A + 2;           // holds 2**A

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    GAP,
    SYM_HI,
    SYM_LO,
    TERM,
    DONE
  } tx_state_t;

  // Number of payload symbols sent for a given n field.
  function automatic logic [SYM_CNT_W-1:0] sym_total(input logic [N_W-1:0] n);
    return SYM_CNT_W'(1) << n;
  endfunction

endpackage

// File: rtl/serial_msg_tx_pw_symbol_gen.sv
// Pulse-width symbol generator: one go pulse emits one symbol. A 1 is a long
// high phase then a short low phase, a 0 is short high then long low.
// The line value held in o_str during a cycle is the value the top level
// registers onto the serial line for the following cycle.
module pw_symbol_gen
  import serial_msg_tx_pkg::*;
#(
  parameter int SYM_LONG  = SYM_LONG_DEF,
  parameter int SYM_SHORT = SYM_SHORT_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_go,
  input  logic i_bit,
  output logic o_str,
  output logic o_sym_done
);

  localparam int PH_MAX = (SYM_LONG > GAP_CYC) ? SYM_LONG : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] LONG_M1  = PH_W'(SYM_LONG - 1);
  localparam logic [PH_W-1:0] SHORT_M1 = PH_W'(SYM_SHORT - 1);

  logic            r_active;
  logic            r_hi;
  logic            r_bit;
  logic [PH_W-1:0] r_cnt;

  // Phase sequencing: high phase, then low phase, then idle unless re-triggered.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_active <= 1'b0;
      r_hi     <= 1'b0;
      r_bit    <= 1'b0;
      r_cnt    <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_hi     <= 1'b1;
      r_bit    <= i_bit;
      r_cnt    <= i_bit ? LONG_M1 : SHORT_M1;
    end else if (r_active) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - PH_W'(1);
      end else if (r_hi) begin
        r_hi  <= 1'b0;
        r_cnt <= r_bit ? SHORT_M1 : LONG_M1;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_str      = r_hi;
  assign o_sym_done = r_active & ~r_hi & (r_cnt == '0);

endmodule

// File: rtl/serial_msg_tx.sv
// Transmit end of the serial key/message link: config frame (n, d, N) on
// mode=1, a short gap, then a pulse-width-coded payload burst, a terminating
// rising edge, and a done pulse. The FSM state always describes the line
// value for the next cycle, so every output is a plain flop.
module serial_msg_tx
  import serial_msg_tx_pkg::*;
#(
  parameter int SYM_LONG  = SYM_LONG_DEF,
  parameter int SYM_SHORT = SYM_SHORT_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  input  logic [D_SIZE-1:0] d_in,
  input  logic [D_SIZE-1:0] N_in,
  input  logic [D_SIZE-1:0] data_in,
  input  logic              abort,
  output logic              str,
  output logic              mode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (!(SYM_LONG > SYM_SHORT && SYM_SHORT >= 1)) begin : g_chk_sym_order
    $error("SYM_LONG must exceed SYM_SHORT and SYM_SHORT must be at least 1");
  end
  if (SYM_LONG + SYM_SHORT < 10 || SYM_LONG + SYM_SHORT > 60) begin : g_chk_sym_window
    $error("symbol length must lie in the receiver accept window 10..60");
  end
  if (D_SIZE != 2 ** A) begin : g_chk_width
    $error("D_SIZE must equal 2**A");
  end
  if (GAP_CYC < 1) begin : g_chk_gap
    $error("GAP_CYC must be at least 1");
  end

  tx_state_t r_state, w_state_nxt;

  logic                 w_clear;
  logic                 w_legal;
  logic                 w_load;
  logic                 w_go;
  logic                 w_gen_str;
  logic                 w_sym_done;
  logic [SYM_CNT_W-1:0] w_shamt;

  logic [CFG_BITS-1:0]  r_cfg_sr;
  logic [D_SIZE-1:0]    r_data_sr;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [SYM_CNT_W-1:0] r_sym_cnt;

  logic r_str, r_mode, r_busy, r_done, r_err;
  logic w_str_nxt, w_mode_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

  // Abort behaves exactly like reset for everything in this block.
  assign w_clear = reset | abort;
  assign w_legal = (n_in <= N_W'(A));
  assign w_load  = (r_state == IDLE) && start && w_legal;
  // Left-justify the payload so bit 2**n-1 sits at the shift-out end.
  assign w_shamt = SYM_CNT_W'(D_SIZE) - sym_total(n_in);

  pw_symbol_gen #(
    .SYM_LONG (SYM_LONG),
    .SYM_SHORT(SYM_SHORT),
    .GAP_CYC  (GAP_CYC)
  ) u_sym_gen (
    .clk       (clk),
    .i_reset   (w_clear),
    .i_go      (w_go),
    .i_bit     (r_data_sr[D_SIZE-1]),
    .o_str     (w_gen_str),
    .o_sym_done(w_sym_done)
  );

  // State register.
  // NOTE: reset is synchronous, so it is tested inside the clocked block and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; also launches each symbol in the generator.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    case (r_state)
      IDLE: if (start && w_legal) w_state_nxt = CFG;
      CFG:  if (r_bit_cnt == BIT_CNT_W'(CFG_BITS - 1)) w_state_nxt = GAP;
      GAP: begin
        if (r_bit_cnt == BIT_CNT_W'(GAP_CYC - 1)) begin
          w_go        = 1'b1;
          w_state_nxt = SYM_HI;
        end
      end
      SYM_HI, SYM_LO: begin
        if (w_sym_done) begin
          if (r_sym_cnt == '0) begin
            w_state_nxt = TERM;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = SYM_HI;
          end
        end else if (r_state == SYM_HI && !w_gen_str) begin
          w_state_nxt = SYM_LO;
        end
      end
      TERM:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode for the next line cycle; IDLE already emits the first n bit.
  always_comb begin
    w_str_nxt  = 1'b0;
    w_mode_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_legal) begin
            w_str_nxt  = n_in[N_W-1];
            w_mode_nxt = 1'b1;
            w_busy_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
          end
        end
      end
      CFG: begin
        w_str_nxt  = r_cfg_sr[CFG_BITS-1];
        w_mode_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      GAP: w_busy_nxt = 1'b1;
      SYM_HI, SYM_LO: begin
        w_str_nxt  = w_gen_str;
        w_busy_nxt = 1'b1;
      end
      TERM: begin
        w_str_nxt  = 1'b1;
        w_busy_nxt = 1'b1;
      end
      DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  // NOTE: sequential state is written with non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_str  <= 1'b0;
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_str  <= w_str_nxt;
      r_mode <= w_mode_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Bit counter (config frame, then reused for the gap) and symbol counter.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_bit_cnt <= '0;
      r_sym_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_legal) begin
            r_bit_cnt <= BIT_CNT_W'(1);
            r_sym_cnt <= sym_total(n_in);
          end
        end
        CFG: begin
          if (r_bit_cnt == BIT_CNT_W'(CFG_BITS - 1)) r_bit_cnt <= '0;
          else                                       r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
        GAP:     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        default: ;
      endcase
      if (w_go) r_sym_cnt <= r_sym_cnt - SYM_CNT_W'(1);
    end
  end

  // Config and payload shift registers; bit 0 of the frame goes out from IDLE.
  // NOTE: these data registers carry no reset; they are always loaded on accept before anything reads them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_cfg_sr  <= {n_in[N_W-2:0], d_in, N_in, 1'b0};
      r_data_sr <= data_in << w_shamt;
    end else begin
      if (r_state == CFG) r_cfg_sr  <= r_cfg_sr << 1;
      if (w_go)           r_data_sr <= r_data_sr << 1;
    end
  end

  assign str  = r_str;
  assign mode = r_mode;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_serial_msg_tx.sv
// Self-checking bench for serial_msg_tx: directed transfers plus a line
// decoder that rebuilds n/d/N and the payload and matches them against a
// scoreboard of expected transfers.
module tb_serial_msg_tx;
  import serial_msg_tx_pkg::*;

  localparam int TB_LONG  = 12;
  localparam int TB_SHORT = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  n_in;
  logic [31:0] d_in, N_in, data_in;
  logic        str, mode, busy, done, err;

  serial_msg_tx dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .n_in   (n_in),
    .d_in   (d_in),
    .N_in   (N_in),
    .data_in(data_in),
    .abort  (abort),
    .str    (str),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;
  int n_push = 0;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] d;
    logic [31:0] m;
    logic [31:0] pay;
    int          syms;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [31:0] low_bits(input logic [31:0] x, input int nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[i] = x[i];
    return r;
  endfunction

  task automatic send(input logic [3:0] n, input logic [31:0] d, input logic [31:0] m,
                      input logic [31:0] data, input bit push, output int s);
    exp_t e;
    s       = cyc;
    n_in    = n;
    d_in    = d;
    N_in    = m;
    data_in = data;
    start   = 1'b1;
    if (push) begin
      e.n        = n;
      e.d        = d;
      e.m        = m;
      e.syms     = 1 << n;
      e.pay      = low_bits(data, e.syms);
      e.done_cyc = s + 68 + 2 + (TB_LONG + TB_SHORT) * e.syms + 2;
      sb.push_back(e);
      n_push++;
    end
    to_cyc(s + 1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("timeout_busy", busy, 0);
  endtask

  // Line decoder: collects the config frame and pulse-width symbols.
  logic [67:0] mon_cfg;
  logic [31:0] mon_pay;
  int          mon_cfg_n, mon_hi, mon_lo, mon_syms, mon_bad, mon_done_cnt;
  logic        mon_in_sym, mon_prev;
  exp_t        mon_e;

  task automatic mon_clear();
    mon_cfg    = '0;
    mon_pay    = '0;
    mon_cfg_n  = 0;
    mon_hi     = 0;
    mon_lo     = 0;
    mon_syms   = 0;
    mon_bad    = 0;
    mon_in_sym = 1'b0;
    mon_prev   = 1'b0;
  endtask

  initial begin
    mon_clear();
    mon_done_cnt = 0;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      mon_done_cnt++;
      check("sb_nonempty_at_done", 68'(sb.size() != 0), 68'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("cfg_len", mon_cfg_n, 68);
        check("cfg_frame", mon_cfg, {mon_e.n, mon_e.d, mon_e.m});
        check("n_field", mon_cfg[67:64], mon_e.n);
        check("sym_count", mon_syms, mon_e.syms);
        check("payload", mon_pay, mon_e.pay);
        check("bad_symbols", mon_bad, 0);
        check("term_len", {mon_hi[31:0], mon_lo[31:0]}, {32'd1, 32'd0});
        check("done_cycle", cyc, mon_e.done_cyc);
        check("str_at_done", str, 0);
      end
      mon_clear();
    end else if (busy !== 1'b1) begin
      mon_clear();
    end else if (mode === 1'b1) begin
      mon_cfg = {mon_cfg[66:0], str};
      mon_cfg_n++;
      mon_prev = str;
    end else begin
      if (str && !mon_prev) begin
        if (mon_in_sym) begin
          if (mon_hi == TB_LONG && mon_lo == TB_SHORT)      mon_pay = {mon_pay[30:0], 1'b1};
          else if (mon_hi == TB_SHORT && mon_lo == TB_LONG) mon_pay = {mon_pay[30:0], 1'b0};
          else                                              mon_bad++;
          mon_syms++;
        end
        mon_in_sym = 1'b1;
        mon_hi     = 1;
        mon_lo     = 0;
      end else if (str) begin
        mon_hi++;
      end else if (mon_in_sym) begin
        mon_lo++;
      end
      mon_prev = str;
    end
  end

  initial begin
    int s;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    n_in    = '0;
    d_in    = '0;
    N_in    = '0;
    data_in = '0;

    // Reset state.
    to_cyc(3);
    check("rst_str", str, 0);
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    to_cyc(5);

    // n=2 reference transfer with an ignored start while busy.
    send(4'd2, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0000_000A, 1'b1, s);
    check("t1_c1_mode", mode, 1);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_str", str, 0);
    to_cyc(s + 3);  check("t1_c3_str", str, 1);
    to_cyc(s + 40);
    n_in  = 4'd1;
    start = 1'b1;
    to_cyc(s + 41);
    start = 1'b0;
    to_cyc(s + 68); check("t1_c68_mode", mode, 1);
    check("t1_c68_str", str, 1);
    to_cyc(s + 69); check("t1_c69_mode", mode, 0);
    check("t1_c69_str", str, 0);
    to_cyc(s + 70); check("t1_c70_str", str, 0);
    to_cyc(s + 71); check("t1_c71_str", str, 1);
    to_cyc(s + 82); check("t1_c82_str", str, 1);
    to_cyc(s + 83); check("t1_c83_str", str, 0);
    to_cyc(s + 87); check("t1_c87_str", str, 1);
    to_cyc(s + 91); check("t1_c91_str", str, 0);
    to_cyc(s + 135); check("t1_term_str", str, 1);
    check("t1_term_done", done, 0);
    to_cyc(s + 136); check("t1_done", done, 1);
    check("t1_done_busy", busy, 1);
    to_cyc(s + 137); check("t1_after_busy", busy, 0);
    check("t1_after_done", done, 0);
    to_cyc(s + 140);

    // n=5 full-width payload, loopback-style key d=1 and large modulus.
    send(4'd5, 32'h0000_0001, 32'hFFFF_FFF1, 32'hDEAD_BEEF, 1'b1, s);
    check("t2_c1_busy", busy, 1);
    to_cyc(s + 583); check("t2_c583_busy", busy, 1);
    check("t2_c583_done", done, 0);
    to_cyc(s + 584); check("t2_done", done, 1);
    to_cyc(s + 585); check("t2_after_busy", busy, 0);
    to_cyc(s + 588);

    // n=0 single zero symbol.
    send(4'd0, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_FFFE, 1'b1, s);
    to_cyc(s + 71); check("t3_hi_first", str, 1);
    to_cyc(s + 74); check("t3_hi_last", str, 1);
    to_cyc(s + 75); check("t3_lo_first", str, 0);
    to_cyc(s + 86); check("t3_lo_last", str, 0);
    to_cyc(s + 87); check("t3_term", str, 1);
    to_cyc(s + 88); check("t3_done", done, 1);
    to_cyc(s + 91);

    // n=6 rejected, then a legal start works.
    send(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s);
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_mode", mode, 0);
    check("t4_str", str, 0);
    to_cyc(s + 2);  check("t4_err_pulse", err, 0);
    check("t4_still_idle", busy, 0);
    to_cyc(s + 4);
    send(4'd1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1234_5672, 1'b1, s);
    check("t4b_mode", mode, 1);
    wait_idle(200);
    to_cyc(cyc + 3);

    // Abort mid-config frame.
    send(4'd3, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_00C3, 1'b0, s);
    to_cyc(s + 30);
    abort = 1'b1;
    to_cyc(s + 31);
    abort = 1'b0;
    check("t5_mode", mode, 0);
    check("t5_str", str, 0);
    check("t5_busy", busy, 0);
    to_cyc(s + 40); check("t5_stays_idle", busy, 0);

    // Reset mid-symbol burst.
    send(4'd2, 32'h1111_2222, 32'h3333_4444, 32'h0000_0005, 1'b0, s);
    to_cyc(s + 80);
    reset = 1'b1;
    to_cyc(s + 81);
    reset = 1'b0;
    check("t6_mode", mode, 0);
    check("t6_str", str, 0);
    check("t6_busy", busy, 0);
    to_cyc(s + 90); check("t6_stays_idle", busy, 0);

    // Recovery with a random payload.
    send(4'd3, $urandom(), $urandom(), $urandom(), 1'b1, s);
    wait_idle(300);
    to_cyc(cyc + 3);

    check("sb_drained", sb.size(), 0);
    check("done_count", mon_done_cnt, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
